// File: rtl/elbeth_fetch_stage_pkg.sv
// Shared constants for the ELBETH IF stage: NOP encoding, fetch exception codes, reset PC.
package elbeth_fetch_stage_pkg;

    localparam logic [31:0] RV_NOP           = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_IF_MISAL = 2'b01;
    localparam logic [1:0] EXC_IF_FAULT = 2'b10;

    // Branch targets are halfword aligned; bit 0 is always dropped.
    function automatic logic [31:0] redirect_target(input logic [31:0] pc_branch);
        return pc_branch & ~32'h0000_0001;
    endfunction

endpackage

// File: rtl/elbeth_fetch_stage_if_skid.sv
// One-entry {pc, instr, exc} holding register that catches a fetch response while ID stalls.
module elbeth_if_skid
    import elbeth_fetch_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic [1:0]  exc_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic [1:0]  exc_o
);

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [1:0]  exc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q    <= 32'h0;
            instr_q <= RV_NOP;
            exc_q   <= EXC_NONE;
        end else if (load_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
            exc_q   <= exc_i;
        end else if (clear_i) begin
            pc_q    <= 32'h0;
            instr_q <= RV_NOP;
            exc_q   <= EXC_NONE;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign exc_o   = exc_q;

endmodule

// File: rtl/elbeth_fetch_stage.sv
// ELBETH IF stage: PC ownership, single-outstanding req/ack fetch, redirect squash, IF/ID register.
module elbeth_fetch_stage
    import elbeth_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_taken,
    input  logic [31:0] pc_branch,
    input  logic        id_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        imem_error,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid,
    output logic [1:0]  if_id_exc
);

    typedef enum logic [1:0] {StFetch, StHold, StDiscard, StMisal} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [1:0]  ifid_exc_q, ifid_exc_d;

    logic        skid_load, skid_clear;
    logic [31:0] skid_pc, skid_instr;
    logic [1:0]  skid_exc;

    logic        redirect;
    logic [31:0] tgt;
    logic [31:0] pc_plus4;
    logic [31:0] ack_instr;
    logic [1:0]  ack_exc;
    logic [31:0] discard_pc;

    assign redirect   = branch_taken & ~id_stall;
    assign tgt        = redirect_target(pc_branch);
    assign pc_plus4   = pc_q + 32'd4;
    assign ack_instr  = imem_error ? RV_NOP : imem_data;
    assign ack_exc    = imem_error ? EXC_IF_FAULT : EXC_NONE;
    // A redirect arriving with the discarded ack supersedes the pending target.
    assign discard_pc = redirect ? tgt : pend_q;

    function automatic state_e entry_state(input logic [31:0] pc);
        return pc[1] ? StMisal : StFetch;
    endfunction

    elbeth_if_skid u_skid (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (pc_q),
        .instr_i (ack_instr),
        .exc_i   (ack_exc),
        .pc_o    (skid_pc),
        .instr_o (skid_instr),
        .exc_o   (skid_exc)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_exc_d   = ifid_exc_q;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;

        unique case (state_q)
            StFetch: begin
                if (imem_ack && id_stall) begin
                    skid_load = 1'b1;
                    pc_d      = pc_plus4;
                    state_d   = StHold;
                end else if (imem_ack && redirect) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = RV_NOP;
                    ifid_exc_d   = EXC_NONE;
                    pc_d         = tgt;
                    state_d      = entry_state(tgt);
                end else if (imem_ack) begin
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = ack_instr;
                    ifid_valid_d = 1'b1;
                    ifid_exc_d   = ack_exc;
                    pc_d         = pc_plus4;
                end else if (!id_stall) begin
                    // Covers redirect too: the in-flight request must still complete.
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = RV_NOP;
                    ifid_exc_d   = EXC_NONE;
                    if (redirect) begin
                        pend_d  = tgt;
                        state_d = StDiscard;
                    end
                end
            end
            StHold: begin
                if (!id_stall) begin
                    skid_clear = 1'b1;
                    if (redirect) begin
                        ifid_valid_d = 1'b0;
                        ifid_instr_d = RV_NOP;
                        ifid_exc_d   = EXC_NONE;
                        pc_d         = tgt;
                        state_d      = entry_state(tgt);
                    end else begin
                        ifid_pc_d    = skid_pc;
                        ifid_instr_d = skid_instr;
                        ifid_valid_d = 1'b1;
                        ifid_exc_d   = skid_exc;
                        state_d      = StFetch;
                    end
                end
            end
            StDiscard: begin
                if (imem_ack) begin
                    pc_d    = discard_pc;
                    state_d = entry_state(discard_pc);
                end else if (redirect) begin
                    pend_d = tgt;
                end
                if (!id_stall) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = RV_NOP;
                    ifid_exc_d   = EXC_NONE;
                end
            end
            StMisal: begin
                if (redirect) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = RV_NOP;
                    ifid_exc_d   = EXC_NONE;
                    pc_d         = tgt;
                    state_d      = entry_state(tgt);
                end else if (!id_stall) begin
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = RV_NOP;
                    ifid_valid_d = 1'b1;
                    ifid_exc_d   = EXC_IF_MISAL;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            pend_q <= RESET_PC;
        end else begin
            pc_q   <= pc_d;
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= RV_NOP;
            ifid_valid_q <= 1'b0;
            ifid_exc_q   <= EXC_NONE;
        end else begin
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_exc_q   <= ifid_exc_d;
        end
    end

    // Gated by rst_n so a request in flight is withdrawn the instant reset asserts.
    assign imem_req          = rst_n & ((state_q == StFetch) | (state_q == StDiscard));
    assign imem_addr         = pc_q;
    assign if_id_pc          = ifid_pc_q;
    assign if_id_instruction = ifid_instr_q;
    assign if_id_valid       = ifid_valid_q;
    assign if_id_exc         = ifid_exc_q;

endmodule
